// File: rtl/frame_buffer_pingpong.sv
// frame_buffer_pingpong
//   Double-buffered (ping-pong) camera frame store. The capture side streams
//   pixels into the write bank while the reader fetches a complete frame from
//   the other bank. Banks swap only after a complete frame, so the reader never
//   sees a torn image.
//
// Optional feature macro: FB_STATS_EN (adds drop/short frame counters).
//
// Ports
//   clk_i          in   clock, rising edge
//   rst            in   synchronous active-high reset
//   wr_sof_i       in   start-of-frame strobe from capture
//   wr_en_i        in   pixel valid
//   wr_dat_i       in   pixel data
//   rd_en_i        in   read request
//   rd_adr_i       in   read address within the read bank
//   rd_dat_o       out  registered read data
//   rd_valid_o     out  rd_dat_o valid (one cycle after rd_en_i)
//   frame_ready_o  out  read bank holds a complete, unconsumed frame
//   frame_ack_i    in   reader finished with the current frame
//   wr_bank_o      out  index of the bank being written
//   drop_cnt_o     out  frames dropped while waiting to swap (FB_STATS_EN only)
//   short_cnt_o    out  frames restarted before completion (FB_STATS_EN only)
module frame_buffer_pingpong #(
    parameter int DATA_W = 12,
    parameter int H_RES  = 160,
    parameter int V_RES  = 120
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              wr_sof_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic [$clog2(H_RES*V_RES)-1:0] rd_adr_i,
    output logic [DATA_W-1:0] rd_dat_o,
    output logic              rd_valid_o,
    output logic              frame_ready_o,
    input  logic              frame_ack_i,
    output logic              wr_bank_o
`ifdef FB_STATS_EN
    ,
    output logic [7:0]        drop_cnt_o,
    output logic [7:0]        short_cnt_o
`endif
);

    localparam int DEPTH  = H_RES * V_RES;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

    // Bank index is the address MSB, so each bank spans a power-of-two window.
    logic [DATA_W-1:0] r_mem [0:(2 << ADDR_W) - 1];

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt, w_wr_adr;
    logic              r_bank, r_ready, r_rd_valid;
    logic [DATA_W-1:0] r_rd_dat;
    logic              w_we, w_swap, w_short, w_drop, w_rd_oob;

    // Writer next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_wr_adr    = r_ptr;
        w_we        = 1'b0;
        w_swap      = 1'b0;
        w_short     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_adr = '0;
                if (wr_sof_i) begin
                    w_state_nxt = ST_FILL;
                    w_ptr_nxt   = '0;
                    // A pixel coincident with SOF is the first pixel of the frame.
                    if (wr_en_i) begin
                        w_we      = 1'b1;
                        w_ptr_nxt = ADDR_W'(1);
                    end
                end
            end
            ST_FILL: begin
                if (wr_sof_i) begin
                    // Short frame: restart from address 0, partial data is abandoned.
                    w_short   = 1'b1;
                    w_ptr_nxt = '0;
                end else if (wr_en_i) begin
                    w_we = 1'b1;
                    if (r_ptr == LAST_ADR) begin
                        w_state_nxt = ST_DONE;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_ptr_nxt = r_ptr + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!r_ready || frame_ack_i) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (wr_sof_i) begin
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_rd_oob = ({1'b0, rd_adr_i} >= DEPTH_EXT);

    // Control and read-data registers
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_bank     <= 1'b0;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_dat   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_rd_valid <= rd_en_i;
            if (w_swap) begin
                r_bank  <= ~r_bank;
                r_ready <= 1'b1;
            end else if (frame_ack_i) begin
                r_ready <= 1'b0;
            end
            // Read bank is taken from the pre-swap bank index.
            if (rd_en_i) begin
                r_rd_dat <= w_rd_oob ? '0 : r_mem[{~r_bank, rd_adr_i}];
            end
        end
    end

    // Storage: write port only, no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (w_we && !rst) begin
            r_mem[{r_bank, w_wr_adr}] <= wr_dat_i;
        end
    end

    assign rd_dat_o      = r_rd_dat;
    assign rd_valid_o    = r_rd_valid;
    assign frame_ready_o = r_ready;
    assign wr_bank_o     = r_bank;

`ifdef FB_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] r_drop_cnt, r_short_cnt;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_drop_cnt  <= '0;
            r_short_cnt <= '0;
        end else begin
            if (w_drop)  r_drop_cnt  <= sat_inc(r_drop_cnt);
            if (w_short) r_short_cnt <= sat_inc(r_short_cnt);
        end
    end

    assign drop_cnt_o  = r_drop_cnt;
    assign short_cnt_o = r_short_cnt;
`endif

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
module tb_frame_buffer_pingpong;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic        wr_sof_i = 1'b0, wr_en_i = 1'b0, rd_en_i = 1'b0, frame_ack_i = 1'b0;
    logic [11:0] wr_dat_i = '0;
    logic [2:0]  rd_adr_i = '0;
    logic [11:0] rd_dat_o;
    logic        rd_valid_o, frame_ready_o, wr_bank_o;

    // Second instance with DEPTH=9 so that addresses >= DEPTH are representable.
    logic        b_sof = 1'b0, b_wr_en = 1'b0, b_rd_en = 1'b0, b_ack = 1'b0;
    logic [11:0] b_wr_dat = '0;
    logic [3:0]  b_rd_adr = '0;
    logic [11:0] b_rd_dat;
    logic        b_rd_valid, b_ready, b_bank;

`ifdef FB_STATS_EN
    logic [7:0] drop_cnt_o, short_cnt_o, b_drop_cnt, b_short_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    frame_buffer_pingpong #(.DATA_W(12), .H_RES(4), .V_RES(2)) dut (
        .clk_i(clk_i), .rst(rst), .wr_sof_i(wr_sof_i), .wr_en_i(wr_en_i),
        .wr_dat_i(wr_dat_i), .rd_en_i(rd_en_i), .rd_adr_i(rd_adr_i),
        .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .frame_ready_o(frame_ready_o),
        .frame_ack_i(frame_ack_i), .wr_bank_o(wr_bank_o)
`ifdef FB_STATS_EN
        , .drop_cnt_o(drop_cnt_o), .short_cnt_o(short_cnt_o)
`endif
    );

    frame_buffer_pingpong #(.DATA_W(12), .H_RES(3), .V_RES(3)) dut9 (
        .clk_i(clk_i), .rst(rst), .wr_sof_i(b_sof), .wr_en_i(b_wr_en),
        .wr_dat_i(b_wr_dat), .rd_en_i(b_rd_en), .rd_adr_i(b_rd_adr),
        .rd_dat_o(b_rd_dat), .rd_valid_o(b_rd_valid), .frame_ready_o(b_ready),
        .frame_ack_i(b_ack), .wr_bank_o(b_bank)
`ifdef FB_STATS_EN
        , .drop_cnt_o(b_drop_cnt), .short_cnt_o(b_short_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_sof();
        wr_sof_i = 1'b1;
        tick();
        wr_sof_i = 1'b0;
    endtask

    task automatic send_px(input logic [11:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en_i  = 1'b1;
            wr_dat_i = base + 12'(i);
            tick();
        end
        wr_en_i = 1'b0;
    endtask

    task automatic pulse_ack();
        frame_ack_i = 1'b1;
        tick();
        frame_ack_i = 1'b0;
    endtask

    task automatic read_px(input logic [2:0] a, output logic [11:0] d, output logic v);
        rd_en_i  = 1'b1;
        rd_adr_i = a;
        tick();
        rd_en_i = 1'b0;
        d = rd_dat_o;
        v = rd_valid_o;
    endtask

    task automatic read9(input logic [3:0] a, output logic [11:0] d, output logic v);
        b_rd_en  = 1'b1;
        b_rd_adr = a;
        tick();
        b_rd_en = 1'b0;
        d = b_rd_dat;
        v = b_rd_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rd_valid_o); end
        n_chk++; if (rd_dat_o !== 12'h000) begin n_fail++; $display("FAIL reset_dat got %h want 000", rd_dat_o); end
        n_chk++; if (frame_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", frame_ready_o); end
        n_chk++; if (wr_bank_o !== 1'b0) begin n_fail++; $display("FAIL reset_bank got %b want 0", wr_bank_o); end
`ifdef FB_STATS_EN
        n_chk++; if ({drop_cnt_o, short_cnt_o} !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", {drop_cnt_o, short_cnt_o}); end
`endif
    endtask

    task automatic test_single_frame();
        logic [11:0] d;
        logic v;
        // pixels ignored in IDLE
        send_px(12'hEEE, 2);
        send_sof();
        send_px(12'h001, 8);
        tick();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b11) begin n_fail++; $display("FAIL t1_swap bank/ready got %b want 11", {wr_bank_o, frame_ready_o}); end
        for (int i = 0; i < 8; i++) begin
            read_px(3'(i), d, v);
            n_chk++; if ({v, d} !== {1'b1, 12'(i + 1)}) begin n_fail++; $display("FAIL t1_read adr %0d got v=%b d=%h want v=1 d=%h", i, v, d, 12'(i + 1)); end
        end
        tick();
        n_chk++; if ({rd_valid_o, rd_dat_o} !== {1'b0, 12'h008}) begin n_fail++; $display("FAIL t1_hold got v=%b d=%h want v=0 d=008", rd_valid_o, rd_dat_o); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] d;
        logic v;
        send_sof();
        send_px(12'h020, 8);
        tick();
        tick();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b11) begin n_fail++; $display("FAIL t2_hold bank/ready got %b want 11", {wr_bank_o, frame_ready_o}); end
        read_px(3'd0, d, v);
        n_chk++; if (d !== 12'h001) begin n_fail++; $display("FAIL t2_oldframe got %h want 001", d); end
        pulse_ack();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b01) begin n_fail++; $display("FAIL t2_ackswap bank/ready got %b want 01", {wr_bank_o, frame_ready_o}); end
        read_px(3'd3, d, v);
        n_chk++; if ({v, d} !== {1'b1, 12'h023}) begin n_fail++; $display("FAIL t2_read3 got v=%b d=%h want v=1 d=023", v, d); end
        read_px(3'd7, d, v);
        n_chk++; if (d !== 12'h027) begin n_fail++; $display("FAIL t2_read7 got %h want 027", d); end
    endtask

    task automatic test_short_frame();
        logic [11:0] d;
        logic v;
        send_sof();
        send_px(12'h050, 5);
        send_sof();
        send_px(12'h100, 8);
        tick();
        n_chk++; if (wr_bank_o !== 1'b0) begin n_fail++; $display("FAIL t3_noswap bank got %b want 0", wr_bank_o); end
        pulse_ack();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b11) begin n_fail++; $display("FAIL t3_swap bank/ready got %b want 11", {wr_bank_o, frame_ready_o}); end
        read_px(3'd0, d, v);
        n_chk++; if (d !== 12'h100) begin n_fail++; $display("FAIL t3_read0 got %h want 100", d); end
        read_px(3'd4, d, v);
        n_chk++; if (d !== 12'h104) begin n_fail++; $display("FAIL t3_read4 got %h want 104", d); end
        read_px(3'd7, d, v);
        n_chk++; if (d !== 12'h107) begin n_fail++; $display("FAIL t3_read7 got %h want 107", d); end
`ifdef FB_STATS_EN
        n_chk++; if (short_cnt_o !== 8'd1) begin n_fail++; $display("FAIL t3_short_cnt got %0d want 1", short_cnt_o); end
`endif
    endtask

    task automatic test_drop();
        logic [11:0] d;
        logic v;
        send_sof();
        send_px(12'h200, 8);
        tick();
        send_sof();
        send_px(12'h300, 8);
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b11) begin n_fail++; $display("FAIL t4_hold bank/ready got %b want 11", {wr_bank_o, frame_ready_o}); end
`ifdef FB_STATS_EN
        n_chk++; if (drop_cnt_o !== 8'd1) begin n_fail++; $display("FAIL t4_drop_cnt got %0d want 1", drop_cnt_o); end
`endif
        pulse_ack();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b01) begin n_fail++; $display("FAIL t4_swap bank/ready got %b want 01", {wr_bank_o, frame_ready_o}); end
        read_px(3'd0, d, v);
        n_chk++; if (d !== 12'h200) begin n_fail++; $display("FAIL t4_read0 got %h want 200", d); end
        read_px(3'd6, d, v);
        n_chk++; if (d !== 12'h206) begin n_fail++; $display("FAIL t4_read6 got %h want 206", d); end
    endtask

    task automatic test_swap_read();
        logic [11:0] d;
        logic v;
        pulse_ack();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b00) begin n_fail++; $display("FAIL t6_ackclear bank/ready got %b want 00", {wr_bank_o, frame_ready_o}); end
        pulse_ack();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b00) begin n_fail++; $display("FAIL t6_ackidle bank/ready got %b want 00", {wr_bank_o, frame_ready_o}); end
        send_sof();
        send_px(12'h400, 8);
        // This read lands on the swap edge and must see the pre-swap read bank.
        read_px(3'd2, d, v);
        n_chk++; if ({v, d} !== {1'b1, 12'h202}) begin n_fail++; $display("FAIL t6_swapread got v=%b d=%h want v=1 d=202", v, d); end
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b11) begin n_fail++; $display("FAIL t6_swap bank/ready got %b want 11", {wr_bank_o, frame_ready_o}); end
        read_px(3'd2, d, v);
        n_chk++; if (d !== 12'h402) begin n_fail++; $display("FAIL t6_newread got %h want 402", d); end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] d;
        logic v;
        send_sof();
        send_px(12'h500, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if ({wr_bank_o, frame_ready_o, rd_valid_o} !== 3'b000) begin n_fail++; $display("FAIL t5_rst bank/ready/valid got %b want 000", {wr_bank_o, frame_ready_o, rd_valid_o}); end
        n_chk++; if (rd_dat_o !== 12'h000) begin n_fail++; $display("FAIL t5_rst_dat got %h want 000", rd_dat_o); end
        send_px(12'h555, 8);
        tick();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b00) begin n_fail++; $display("FAIL t5_noswap bank/ready got %b want 00", {wr_bank_o, frame_ready_o}); end
        send_sof();
        send_px(12'h600, 8);
        tick();
        n_chk++; if ({wr_bank_o, frame_ready_o} !== 2'b11) begin n_fail++; $display("FAIL t5_swap bank/ready got %b want 11", {wr_bank_o, frame_ready_o}); end
        read_px(3'd0, d, v);
        n_chk++; if ({v, d} !== {1'b1, 12'h600}) begin n_fail++; $display("FAIL t5_read0 got v=%b d=%h want v=1 d=600", v, d); end
        read_px(3'd7, d, v);
        n_chk++; if (d !== 12'h607) begin n_fail++; $display("FAIL t5_read7 got %h want 607", d); end
    endtask

    task automatic test_out_of_range();
        logic [11:0] d;
        logic v;
        b_sof = 1'b1;
        tick();
        b_sof = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b_wr_en  = 1'b1;
            b_wr_dat = 12'h700 + 12'(i);
            tick();
        end
        b_wr_en = 1'b0;
        tick();
        n_chk++; if ({b_bank, b_ready} !== 2'b11) begin n_fail++; $display("FAIL oob_swap bank/ready got %b want 11", {b_bank, b_ready}); end
        read9(4'd8, d, v);
        n_chk++; if ({v, d} !== {1'b1, 12'h708}) begin n_fail++; $display("FAIL oob_last got v=%b d=%h want v=1 d=708", v, d); end
        read9(4'd9, d, v);
        n_chk++; if ({v, d} !== {1'b1, 12'h000}) begin n_fail++; $display("FAIL oob_adr9 got v=%b d=%h want v=1 d=000", v, d); end
        read9(4'd0, d, v);
        n_chk++; if (d !== 12'h700) begin n_fail++; $display("FAIL oob_first got %h want 700", d); end
        read9(4'd15, d, v);
        n_chk++; if ({v, d} !== {1'b1, 12'h000}) begin n_fail++; $display("FAIL oob_adr15 got v=%b d=%h want v=1 d=000", v, d); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_drop();
        test_swap_read();
        test_reset_midframe();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
